// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one instruction-bus request at a time,
// forwards fetched words to decode, and handles stalls and redirects.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned pc reports
// INSTRMISALIGN instead of issuing a bus request).

package fetch_stage_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  typedef enum logic [1:0] {
    NOERROR       = 2'd0,
    INSTRMISALIGN = 2'd1
  } fetch_err_e;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [ILEN-1:0]  raw_instr;
    fetch_err_e       error;
  } fetch_data_t;

endpackage

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stopd,
  input  logic            stope,
  input  logic            stopm,
  input  logic            branch,
  input  logic [XLEN-1:0] branch_target,
  input  logic            flushde,
  input  logic [XLEN-1:0] flush_target,
  output logic            ireq_valid,
  output logic [XLEN-1:0] ireq_addr,
  input  logic            iresp_ok,
  input  logic [ILEN-1:0] iresp_data,
  output fetch_data_t     dataF
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_e;

  state_e          state_q,      state_d;
  logic [XLEN-1:0] pc_q,         pc_d;
  fetch_data_t     data_q,       data_d;
  logic [ILEN-1:0] hold_q,       hold_d;
  logic            ireq_valid_q, ireq_valid_d;
  logic [XLEN-1:0] ireq_addr_q,  ireq_addr_d;
  logic            err_sent_q,   err_sent_d;

  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] pc_inc;

  // Stall/redirect qualification; flush wins over branch
  always_comb begin
    stall       = stopd | stope | stopm;
    redirect    = flushde | branch;
    redirect_pc = flushde ? flush_target : branch_target;
    pc_inc      = pc_q + XLEN'(4);
  end

  // Next-state, next-pc, decode payload and bus request
  always_comb begin
    logic misal_now;

    state_d      = state_q;
    pc_d         = pc_q;
    data_d       = data_q;
    hold_d       = hold_q;
    ireq_valid_d = 1'b0;
    ireq_addr_d  = ireq_addr_q;
    err_sent_d   = err_sent_q;
    misal_now    = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    misal_now    = (pc_q[1:0] != 2'b00);
`endif

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end

      REQ: begin
        if (redirect) begin
          // An outstanding request whose response is not here yet must be drained
          data_d.valid = 1'b0;
          pc_d         = redirect_pc;
          hold_d       = '0;
          err_sent_d   = 1'b0;
          state_d      = (iresp_ok || misal_now) ? REQ : DISCARD;
        end else if (misal_now) begin
          // No bus traffic; report the fault once, then idle until redirected
          if (!stall) begin
            if (!err_sent_q) begin
              data_d     = '{valid: 1'b1, pc: pc_q, raw_instr: '0, error: INSTRMISALIGN};
              err_sent_d = 1'b1;
            end else begin
              data_d.valid = 1'b0;
            end
          end
        end else if (iresp_ok) begin
          if (stall) begin
            hold_d  = iresp_data;
            state_d = HOLD;
          end else begin
            data_d = '{valid: 1'b1, pc: pc_q, raw_instr: iresp_data, error: NOERROR};
            pc_d   = pc_inc;
          end
        end else if (!stall) begin
          data_d.valid = 1'b0;
        end
      end

      HOLD: begin
        if (redirect) begin
          data_d.valid = 1'b0;
          pc_d         = redirect_pc;
          hold_d       = '0;
          err_sent_d   = 1'b0;
          state_d      = REQ;
        end else if (!stall) begin
          data_d  = '{valid: 1'b1, pc: pc_q, raw_instr: hold_q, error: NOERROR};
          pc_d    = pc_inc;
          hold_d  = '0;
          state_d = REQ;
        end
      end

      DISCARD: begin
        // Stale response is dropped; only the target pc can change here
        if (redirect) begin
          data_d.valid = 1'b0;
          pc_d         = redirect_pc;
          err_sent_d   = 1'b0;
        end
        if (iresp_ok) begin
          state_d = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Request for the upcoming cycle; DISCARD keeps the old address on the bus
    if (state_d == DISCARD) begin
      ireq_valid_d = 1'b1;
    end else if (state_d == REQ) begin
      ireq_valid_d = 1'b1;
      ireq_addr_d  = {pc_d[XLEN-1:2], 2'b00};
`ifdef FETCH_MISALIGN_CHECK_EN
      if (pc_d[1:0] != 2'b00) begin
        ireq_valid_d = 1'b0;
      end
`endif
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      data_q       <= '0;
      hold_q       <= '0;
      ireq_valid_q <= 1'b0;
      ireq_addr_q  <= {RESET_PC[XLEN-1:2], 2'b00};
      err_sent_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      data_q       <= data_d;
      hold_q       <= hold_d;
      ireq_valid_q <= ireq_valid_d;
      ireq_addr_q  <= ireq_addr_d;
      err_sent_q   <= err_sent_d;
    end
  end

  assign ireq_valid = ireq_valid_q;
  assign ireq_addr  = ireq_addr_q;
  assign dataF      = data_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage plus hand-written corner sequences.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [63:0] B = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        reset;
  logic        stopd, stope, stopm;
  logic        branch, flushde;
  logic [63:0] branch_target, flush_target;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_ok;
  logic [31:0] iresp_data;
  fetch_data_t dataF;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_stage #(.RESET_PC(B)) dut (
    .clk           (clk),
    .reset         (reset),
    .stopd         (stopd),
    .stope         (stope),
    .stopm         (stopm),
    .branch        (branch),
    .branch_target (branch_target),
    .flushde       (flushde),
    .flush_target  (flush_target),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_ok      (iresp_ok),
    .iresp_data    (iresp_data),
    .dataF         (dataF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  stop;   // {stopd, stope, stopm}
    logic        br;
    logic        fl;
    logic [63:0] bt;
    logic [63:0] ft;
    logic        ok;
    logic [31:0] data;
    logic        e_rv;
    logic [63:0] e_addr;
    logic        e_v;
    logic [63:0] e_pc;
    logic [31:0] e_ins;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] stop, input logic br, input logic fl,
                              input logic [63:0] bt, input logic [63:0] ft,
                              input logic ok, input logic [31:0] data,
                              input logic e_rv, input logic [63:0] e_addr,
                              input logic e_v, input logic [63:0] e_pc,
                              input logic [31:0] e_ins);
    vec_t v;
    v.stop = stop; v.br = br; v.fl = fl; v.bt = bt; v.ft = ft;
    v.ok = ok; v.data = data; v.e_rv = e_rv; v.e_addr = e_addr;
    v.e_v = e_v; v.e_pc = e_pc; v.e_ins = e_ins;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stopd = 1'b0; stope = 1'b0; stopm = 1'b0;
    branch = 1'b0; flushde = 1'b0;
    branch_target = '0; flush_target = '0;
    iresp_ok = 1'b0; iresp_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Stimulus table: inputs before the edge, expected registered outputs after it
    vecs.push_back(mk(3'b000,0,0,0,0, 0,32'h0,         1,B,        0,0,0));
    vecs.push_back(mk(3'b000,0,0,0,0, 1,32'hA000_0013, 1,B+4,      1,B,      32'hA000_0013));
    vecs.push_back(mk(3'b000,0,0,0,0, 1,32'hA100_0013, 1,B+8,      1,B+4,    32'hA100_0013));
    vecs.push_back(mk(3'b000,0,0,0,0, 1,32'hA200_0013, 1,B+'hC,    1,B+8,    32'hA200_0013));
    vecs.push_back(mk(3'b100,0,0,0,0, 1,32'hA300_0013, 0,0,        1,B+8,    32'hA200_0013));
    vecs.push_back(mk(3'b100,0,0,0,0, 0,32'h0,         0,0,        1,B+8,    32'hA200_0013));
    vecs.push_back(mk(3'b100,0,0,0,0, 1,32'hDEAD_BEEF, 0,0,        1,B+8,    32'hA200_0013));
    vecs.push_back(mk(3'b000,0,0,0,0, 0,32'h0,         1,B+'h10,   1,B+'hC,  32'hA300_0013));
    vecs.push_back(mk(3'b000,1,0,B+'h1000,0, 0,32'h0,  1,B+'h10,   0,0,0));
    vecs.push_back(mk(3'b000,0,0,0,0, 0,32'h0,         1,B+'h10,   0,0,0));
    vecs.push_back(mk(3'b000,0,0,0,0, 1,32'hBAD0_0000, 1,B+'h1000, 0,0,0));
    vecs.push_back(mk(3'b000,0,0,0,0, 1,32'hB000_0013, 1,B+'h1004, 1,B+'h1000,32'hB000_0013));
    vecs.push_back(mk(3'b000,1,1,B+'h300,B+'h200, 1,32'hBAD1_0000, 1,B+'h200, 0,0,0));
    vecs.push_back(mk(3'b000,0,0,0,0, 1,32'hC000_0013, 1,B+'h204,  1,B+'h200,32'hC000_0013));
    vecs.push_back(mk(3'b001,1,0,B+'h400,0, 0,32'h0,   1,B+'h204,  0,0,0));
    vecs.push_back(mk(3'b000,0,1,0,B+'h500, 0,32'h0,   1,B+'h204,  0,0,0));
    vecs.push_back(mk(3'b000,0,0,0,0, 1,32'hBAD2_0000, 1,B+'h500,  0,0,0));
    vecs.push_back(mk(3'b000,0,0,0,0, 1,32'hD000_0013, 1,B+'h504,  1,B+'h500,32'hD000_0013));
    vecs.push_back(mk(3'b100,0,0,0,0, 1,32'hD100_0013, 0,0,        1,B+'h500,32'hD000_0013));
    vecs.push_back(mk(3'b100,1,0,B+'h600,0, 0,32'h0,   1,B+'h600,  0,0,0));
    vecs.push_back(mk(3'b000,0,0,0,0, 1,32'hE000_0013, 1,B+'h604,  1,B+'h600,32'hE000_0013));

    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    chk("reset ireq_valid", 64'(ireq_valid), 64'd0);
    chk("reset dataF.valid", 64'(dataF.valid), 64'd0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      {stopd, stope, stopm} = vecs[i].stop;
      branch = vecs[i].br; branch_target = vecs[i].bt;
      flushde = vecs[i].fl; flush_target = vecs[i].ft;
      iresp_ok = vecs[i].ok; iresp_data = vecs[i].data;
      tick();
      chk($sformatf("row%0d ireq_valid", i), 64'(ireq_valid), 64'(vecs[i].e_rv));
      if (vecs[i].e_rv)
        chk($sformatf("row%0d ireq_addr", i), ireq_addr, vecs[i].e_addr);
      chk($sformatf("row%0d dataF.valid", i), 64'(dataF.valid), 64'(vecs[i].e_v));
      if (vecs[i].e_v) begin
        chk($sformatf("row%0d dataF.pc", i), dataF.pc, vecs[i].e_pc);
        chk($sformatf("row%0d dataF.raw_instr", i), 64'(dataF.raw_instr), 64'(vecs[i].e_ins));
        chk($sformatf("row%0d dataF.error", i), 64'(dataF.error), 64'(NOERROR));
      end
    end
    idle_inputs();

    // pc wraps modulo 2^64
    branch = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC; iresp_ok = 1'b1;
    tick();
    chk("wrap ireq_addr pre", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    branch = 1'b0; iresp_data = 32'hF000_0013;
    tick();
    chk("wrap dataF.pc", dataF.pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap ireq_addr post", ireq_addr, 64'h0);

    // Branch to a misaligned target
    branch = 1'b1; branch_target = B + 64'h2; iresp_ok = 1'b1;
    tick();
    branch = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    iresp_ok = 1'b0;
    chk("misal ireq_valid 0", 64'(ireq_valid), 64'd0);
    chk("misal dataF.valid 0", 64'(dataF.valid), 64'd0);
    tick();
    chk("misal ireq_valid 1", 64'(ireq_valid), 64'd0);
    chk("misal dataF.valid", 64'(dataF.valid), 64'd1);
    chk("misal dataF.pc", dataF.pc, B + 64'h2);
    chk("misal dataF.error", 64'(dataF.error), 64'(INSTRMISALIGN));
    chk("misal raw_instr", 64'(dataF.raw_instr), 64'd0);
    tick();
    chk("misal ireq_valid 2", 64'(ireq_valid), 64'd0);
    chk("misal no repeat", 64'(dataF.valid), 64'd0);
`else
    chk("unal ireq_valid", 64'(ireq_valid), 64'd1);
    chk("unal ireq_addr", ireq_addr, B);
    iresp_data = 32'h6000_0013;
    tick();
    chk("unal dataF.pc", dataF.pc, B + 64'h2);
    chk("unal dataF.error", 64'(dataF.error), 64'(NOERROR));
    chk("unal next addr", ireq_addr, B + 64'h4);
`endif

    // Reset pulsed mid-request with a late response
    branch = 1'b1; branch_target = B + 64'h700; iresp_ok = 1'b1;
    tick();
    branch = 1'b0; iresp_data = 32'h7000_0013;
    tick();
    chk("pre-reset dataF.valid", 64'(dataF.valid), 64'd1);
    chk("pre-reset dataF.pc", dataF.pc, B + 64'h700);
    iresp_ok = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("async reset dataF.valid", 64'(dataF.valid), 64'd0);
    chk("async reset ireq_valid", 64'(ireq_valid), 64'd0);
    iresp_ok = 1'b1; iresp_data = 32'hBAD3_0000;
    tick();
    chk("in reset ireq_valid", 64'(ireq_valid), 64'd0);
    chk("in reset dataF.valid", 64'(dataF.valid), 64'd0);
    reset = 1'b1;
    tick();
    chk("restart ireq_valid", 64'(ireq_valid), 64'd1);
    chk("restart ireq_addr", ireq_addr, B);
    chk("restart dataF.valid", 64'(dataF.valid), 64'd0);
    iresp_data = 32'h1000_0013;
    tick();
    chk("restart dataF.valid 2", 64'(dataF.valid), 64'd1);
    chk("restart dataF.pc", dataF.pc, B);
    chk("restart raw_instr", 64'(dataF.raw_instr), 64'h1000_0013);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, default 64'h0000_0000_8000_0000, PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset (reset==0 asserts).
REQ-004 stopd, stope, stopm  input  1 each  downstream stall; stall = stopd|stope|stopm.
REQ-005 branch  input  1  branch redirect from execute; branch_target  input  64  new PC.
REQ-006 flushde  input  1  exception/CSR redirect; flush_target  input  64  new PC.
REQ-007 ireq_valid  output  1  instruction bus request; ireq_addr  output  64  request address.
REQ-008 iresp_ok  input  1  request complete this cycle; iresp_data  input  32  instruction word.
REQ-009 dataF  output  fetch_data_t  registered {valid, pc, raw_instr, error} consumed by decode.

Function
REQ-010 The block SHALL implement states IDLE, REQ, HOLD, DISCARD.
REQ-011 IDLE: entered on reset; SHALL move to REQ on the first edge after reset deasserts; ireq_valid=0.
REQ-012 REQ: ireq_valid=1, ireq_addr=pc; address SHALL stay stable until iresp_ok.
REQ-013 REQ, iresp_ok, no stall, no redirect: dataF <= {1, pc, iresp_data, NOERROR}, pc <= pc+4, stay REQ (back-to-back, 1 instr/cycle on 0-wait bus).
REQ-014 REQ, iresp_ok, stall, no redirect: iresp_data captured in hold register, dataF unchanged, go HOLD.
REQ-015 REQ, no iresp_ok, no stall, no redirect: dataF.valid <= 0 (bubble).
REQ-016 Any stall without redirect SHALL leave dataF bit-exact unchanged.
REQ-017 HOLD: ireq_valid=0; when stall drops, dataF <= held word with held pc, pc <= pc+4, go REQ.
REQ-018 Redirect = flushde|branch; flushde SHALL take priority over branch; redirect SHALL take priority over stall.
REQ-019 On redirect: dataF.valid <= 0, pc <= selected target; hold register discarded.
REQ-020 Redirect in REQ without iresp_ok that cycle: go DISCARD; otherwise go REQ.
REQ-021 DISCARD: ireq_valid=1 with the old address until iresp_ok; that response SHALL be dropped; then go REQ with new pc; a further redirect in DISCARD updates pc only.
REQ-022 pc SHALL wrap modulo 2^64 on +4.
REQ-023 dataF.valid SHALL never be 1 for a word fetched before the most recent redirect.

Reset
REQ-024 reset==0 SHALL asynchronously force state=IDLE, pc=RESET_PC, dataF.valid=0, ireq_valid=0, hold register cleared.
REQ-025 Reset asserted mid-request SHALL abandon the request; a late iresp_ok after reset SHALL be ignored (IDLE).

Configuration
REQ-026 Macro FETCH_MISALIGN_CHECK_EN: when defined, pc[1:0]!=0 in REQ SHALL issue no bus request (ireq_valid=0) and, if no stall, produce dataF={1, pc, 32'h0, INSTRMISALIGN}, then wait in REQ without advancing pc until a redirect.
REQ-027 Without FETCH_MISALIGN_CHECK_EN, ireq_addr SHALL be {pc[63:2],2'b00} and error is always NOERROR.

Verification
REQ-028 Reset release, iresp_ok tied 1 -> dataF.pc 0x80000000, 0x80000004, 0x80000008 on consecutive cycles, valid=1.
REQ-029 iresp_ok with stopd=1 for 3 cycles -> dataF unchanged 3 cycles, ireq_valid=0, held word appears cycle after stopd drops.
REQ-030 branch=1 target 0x80001000 while request to 0x80000010 pending 2 more cycles -> old response dropped, next ireq_addr=0x80001000, no valid dataF with pc 0x80000010.
REQ-031 flushde (target 0x80000200) and branch (target 0x80000300) same cycle -> next ireq_addr=0x80000200.
REQ-032 FETCH_MISALIGN_CHECK_EN, branch to 0x80000002 -> ireq_valid=0, dataF.error=INSTRMISALIGN, pc=0x80000002.
REQ-033 Reset pulsed low mid-request -> dataF.valid=0 immediately, fetch restarts at 0x80000000.
